// File: rtl/multiword_cla_sequencer.sv
// Multi-word adder/subtractor: walks WORDS 16-bit slices through a single
// 16-bit carry-lookahead adder, one slice per cycle, LSB slice first.

module cla_16bits_LCU (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic [3:0]  P,
    output logic [3:0]  G
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] bc;
    logic [3:0]  gc;

    assign p = in1 ^ in2;
    assign g = in1 & in2;

    // Lookahead carry unit across the four 4-bit groups
    assign gc[0] = cin;
    assign gc[1] = G[0] | (P[0] & cin);
    assign gc[2] = G[1] | (P[1] & G[0]) | (P[1] & P[0] & cin);
    assign gc[3] = G[2] | (P[2] & G[1]) | (P[2] & P[1] & G[0]) | (P[2] & P[1] & P[0] & cin);
    assign cout  = G[3] | (P[3] & G[2]) | (P[3] & P[2] & G[1]) | (P[3] & P[2] & P[1] & G[0])
                 | (P[3] & P[2] & P[1] & P[0] & cin);

    for (genvar j = 0; j < 4; j++) begin : g_grp
        logic [3:0] pp;
        logic [3:0] gg;
        assign pp = p[4*j +: 4];
        assign gg = g[4*j +: 4];
        assign P[j] = &pp;
        assign G[j] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign bc[4*j]   = gc[j];
        assign bc[4*j+1] = gg[0] | (pp[0] & gc[j]);
        assign bc[4*j+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc[j]);
        assign bc[4*j+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & gc[j]);
    end

    assign sum = p ^ bc;
endmodule

module multiword_cla_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                cout,
    output logic                overflow
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          carry;
    logic [15:0]   slice_a;
    logic [15:0]   slice_b;
    logic [15:0]   slice_sum;
    logic          slice_cout;
    logic [3:0]    unused_p;
    logic [3:0]    unused_g;
    logic          accept;
    logic          last;
    logic          msb_carry_in;

    assign slice_a = op_a[{idx, 4'b0000} +: 16];
    assign slice_b = op_b[{idx, 4'b0000} +: 16];

    cla_16bits_LCU u_cla (
        .in1  (slice_a),
        .in2  (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout),
        .P    (unused_p),
        .G    (unused_g)
    );

    assign accept = start && (state != RUN);
    assign last   = (idx == LAST_IDX);
    // Recover the carry into the MSB from the MSB sum bit and its operands
    assign msb_carry_in = op_a[W-1] ^ op_b[W-1] ^ slice_sum[15];
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b now, inject the +1 as carry-in
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[{idx, 4'b0000} +: 16] <= slice_sum;
            carry <= slice_cout;
            if (last) begin
                idx      <= '0;
                cout     <= slice_cout;
                overflow <= msb_carry_in ^ slice_cout;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multiword_cla_sequencer.sv
// Directed bench for multiword_cla_sequencer (WORDS=4, 64-bit operands):
// hand-computed vectors, one checking task, bounded waits on done.

module tb_multiword_cla_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_vec = 0;
    int n_mis = 0;

    multiword_cla_sequencer #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents operands with start for one edge, then
    // scrambles the inputs so only latched copies can produce the result.
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vcin, input logic vsub, input string tag);
        a     = va;
        b     = vb;
        cin   = vcin;
        sub   = vsub;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 64'hDEAD_BEEF_A5A5_5A5A;
        b     = 64'h0123_4567_89AB_CDEF;
        cin   = ~vcin;
        sub   = ~vsub;
        chk({tag, ".busy"}, 64'(busy), 64'd1);
    endtask

    // Waits (bounded) at negedges for done; checks how many negedges it took.
    task automatic wait_done(input int exp_lat, input string tag);
        int n = 0;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic check_result(input logic [W-1:0] es, input logic ec,
                                input logic eo, input string tag);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".busy_low"}, 64'(busy), 64'd0);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, 64'(cout), 64'(ec));
        chk({tag, ".ovf"}, 64'(overflow), 64'(eo));
    endtask

    initial begin
        int dones;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.sum", sum, 64'd0);
        chk("rst.cout", 64'(cout), 64'd0);
        chk("rst.ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Carry ripples through all four slices
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, "add_carry");
        wait_done(4, "add_carry");
        check_result(64'h0, 1'b1, 1'b0, "add_carry");
        @(negedge clk);
        chk("idle.done", 64'(done), 64'd0);

        launch(64'h5, 64'h7, 1'b0, 1'b1, "sub_neg");
        wait_done(4, "sub_neg");
        check_result(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        @(negedge clk);

        launch(64'h7, 64'h5, 1'b0, 1'b1, "sub_pos");
        wait_done(4, "sub_pos");
        check_result(64'h2, 1'b1, 1'b0, "sub_pos");
        @(negedge clk);

        launch(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, "ovf_add");
        wait_done(4, "ovf_add");
        check_result(64'h8000_0000_0000_0000, 1'b0, 1'b1, "ovf_add");
        @(negedge clk);

        // 0x8000.. + 0xFFFF..FE + 1 carries out of the MSB (no borrow)
        launch(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, "ovf_sub");
        wait_done(4, "ovf_sub");
        check_result(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "ovf_sub");
        @(negedge clk);

        // Add with carry-in, and a start pulse during RUN that must be ignored
        launch(64'h3, 64'h4, 1'b1, 1'b0, "ign");
        @(negedge clk);
        a     = 64'h1234;
        b     = 64'h1;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, "ign");
        check_result(64'h8, 1'b0, 1'b0, "ign");
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("ign.extra_dones", 64'(dones), 64'd0);
        chk("ign.idle_busy", 64'(busy), 64'd0);

        // Async reset in the middle of RUN at idx=2
        launch(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, 1'b0, "arst");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.done", 64'(done), 64'd0);
        chk("arst.sum", sum, 64'd0);
        chk("arst.cout", 64'(cout), 64'd0);
        chk("arst.ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst.stay_idle", 64'(busy), 64'd0);
        launch(64'h10, 64'h20, 1'b1, 1'b0, "post_rst");
        wait_done(4, "post_rst");
        check_result(64'h31, 1'b0, 1'b0, "post_rst");
        @(negedge clk);

        // Back-to-back: start asserted during the DONE cycle
        launch(64'h1, 64'h1, 1'b0, 1'b0, "b2b_first");
        wait_done(4, "b2b_first");
        check_result(64'h2, 1'b0, 1'b0, "b2b_first");
        launch(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, "b2b");
        wait_done(4, "b2b");
        check_result(64'h0001_0000_0001_0000, 1'b0, 1'b0, "b2b");
        @(negedge clk);
        chk("b2b.idle_done", 64'(done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/multiword_cla_sequencer.md
Name: multiword_cla_sequencer

Overview:
- Sequential wide-operand adder/subtractor built around one cla_16bits_LCU instance (ports in1, in2, cin, sum, cout, P, G).
- Stage directly upstream and downstream of that adder: slices wide operands into 16-bit words, feeds one word pair per cycle, and registers the carry between words.
- Collects each 16-bit sum slice into a wide result register.
- Gives datapath-level 16*WORDS-bit addition with one 16-bit CLA in hardware.

Parameters:
- WORDS, 4, number of 16-bit slices; operand width W = 16*WORDS; legal range 2..8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- a  input  W  first operand; two's complement or unsigned.
- b  input  W  second operand.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0 = a+b+cin; 1 = a-b (computed as a + ~b + 1).
- busy  output  1  high while operation in progress (state RUN).
- done  output  1  one-cycle pulse; result valid.
- sum  output  W  registered result; held until next accepted start.
- cout  output  1  carry out of bit W-1; held with sum.
- overflow  output  1  signed overflow of the W-bit result; held with sum.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE immediately.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - Slice index=0, carry register=0, operand registers=0.
  - An operation in flight is aborted with no partial result retained.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch A<=a and B<=(sub ? ~b : b).
  - carry<=(sub ? 1 : cin), idx<=0.
  - Go to RUN.
  - sum, cout and overflow keep their old values until written.
- RUN, each cycle:
  - Adder inputs are A[16*idx+:16], B[16*idx+:16] and carry (combinational).
  - On the edge: sum[16*idx+:16]<=adder sum, carry<=adder cout, idx<=idx+1.
  - After the slice idx=WORDS-1 is written:
    - cout<=adder cout.
    - overflow<=(carry into bit W-1) XOR (carry out of bit W-1), where carry into MSB = A[W-1]^B[W-1]^sum bit W-1.
    - Go to DONE.
  - P and G outputs of the adder are unused.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - Next state is IDLE, or RUN if start=1 (back-to-back accept, same latch actions as IDLE).
- Latency: start sampled at edge k puts busy high for cycles k+1..k+WORDS and done high in cycle k+WORDS+1 (5 cycles for WORDS=4). Throughput is one operation per WORDS+1 cycles.
- start while busy=1 is ignored; no queueing, and operands are not relatched.
- a, b, cin and sub may change freely after the accepting edge; only latched copies are used.
- idx wraps to 0 on leaving RUN. No out-of-range slice access.
- Unsigned borrow in sub mode: cout=0 means a<b, cout=1 means a>=b.

Test Plan:
- WORDS=4, add: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0, sub=0 -> done in 5th cycle after start; sum=0x0000_0000_0000_0000, cout=1, overflow=0. This checks carry through all 4 slices.
- Subtract: a=0x5, b=0x7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0. A second run with a=0x7, b=0x5 -> sum=0x2, cout=1.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, sub=0 -> sum=0x8000_0000_0000_0000, overflow=1, cout=0. Then a=0x8000_0000_0000_0000, b=0x1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- start pulsed again in RUN cycle 2 with a=0x1234, b=0x1 -> ignored; result equals the first operation; exactly one done pulse.
- rst raised mid-cycle during RUN (idx=2) -> busy, done, sum, cout and overflow go to 0 before the next clock edge. After release, start with a=0x10, b=0x20, cin=1 -> sum=0x31.
- Back-to-back: start held high in the DONE cycle with a=0x0000_FFFF_0000_FFFF, b=0x0000_0001_0000_0001 -> new operation accepted with no IDLE cycle. Result sum=0x0001_0000_0001_0000; done 5 cycles later.
